// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                                |
// | Description : Data-side memory-stage responder. Captures a dren/dwen       |
// |               request into a word-addressed store and answers with a       |
// |               single-cycle dhit after LAT wait cycles.                      |
// |               Optional macro DMEM_MISALIGN_CHK_EN enables misalignment     |
// |               detection (err flag, blocked writes, poison read data).      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dmem_responder #(
   parameter int DEPTH = 256,
   parameter int LAT   = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dren,
   input  logic        dwen,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dstore,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        busy,
   output logic        err
);

   localparam int          c_aw      = $clog2(DEPTH);
   localparam logic [3:0]  c_lat     = 4'(LAT);
   localparam logic [31:0] c_bad_rd  = 32'hBAD0BAD0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_next;
   logic [c_aw-1:0]   r_idx;
   logic [31:0]       r_data;
   logic              r_wr;
   logic              r_mis;
   logic [31:0]       r_mem [DEPTH];

   logic              w_req;
   logic              w_capture;
   logic              w_mis;
   logic              w_commit;
   logic              unused_addr_bits;

   assign w_req     = dren | dwen;
   assign w_capture = (r_state == S_IDLE) && w_req;
   // The write lands on the edge that leaves RESP, so a following capture
   // (at the earliest one edge later) already sees the new data.
   assign w_commit  = (r_state == S_RESP) && r_wr && !r_mis;

`ifdef DMEM_MISALIGN_CHK_EN
   assign w_mis            = (dmemaddr[1:0] != 2'b00);
   assign unused_addr_bits = ^dmemaddr[31:c_aw+2];
`else
   assign w_mis            = 1'b0;
   assign unused_addr_bits = ^{dmemaddr[31:c_aw+2], dmemaddr[1:0]};
`endif

   // State and wait-counter register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state/counter logic and outputs decoded from registered state only.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      dhit         = 1'b0;
      dmemload     = 32'd0;
      busy         = 1'b0;
      err          = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (c_lat != 4'd0) begin
                  w_state_next = S_WAIT;
                  w_cnt_next   = c_lat;
               end else begin
                  w_state_next = S_RESP;
               end
            end
         end
         S_WAIT: begin
            busy = 1'b1;
            if (!w_req) begin
               // Requester gave up: drop the captured request entirely.
               w_state_next = S_IDLE;
               w_cnt_next   = 4'd0;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  w_state_next = S_RESP;
               end
            end
         end
         S_RESP: begin
            busy         = 1'b1;
            dhit         = 1'b1;
            w_state_next = S_IDLE;
            w_cnt_next   = 4'd0;
            if (!r_wr) begin
               dmemload = r_mis ? c_bad_rd : r_mem[r_idx];
            end
`ifdef DMEM_MISALIGN_CHK_EN
            err = r_mis;
`endif
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = 4'd0;
         end
      endcase
   end

   // Request capture; later changes on the inputs are ignored until IDLE.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_idx  <= '0;
         r_data <= 32'd0;
         r_wr   <= 1'b0;
         r_mis  <= 1'b0;
      end else if (w_capture) begin
         r_idx  <= dmemaddr[c_aw+1:2];
         r_data <= dstore;
         r_wr   <= dwen;
         r_mis  <= w_mis;
      end
   end

   // Word store: cleared by reset, written when a write response retires.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'd0;
         end
      end else if (w_commit) begin
         r_mem[r_idx] <= r_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                             |
// | Description : Self-checking bench for dmem_responder (LAT=2 and LAT=0      |
// |               instances). Honours DMEM_MISALIGN_CHK_EN when defined.       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

   localparam int TB_LAT = 2;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk;
   logic        nRST;
   logic        dren, dwen;
   logic [31:0] dmemaddr, dstore;
   logic        dhit, busy, err;
   logic [31:0] dmemload;

   logic        dren0, dwen0;
   logic [31:0] addr0, data0;
   logic        dhit0, busy0, err0;
   logic [31:0] load0;

   logic [31:0] model [256];
   exp_t        sb [$];
   int          n_checks;
   int          n_fail;

   dmem_responder #(.DEPTH(256), .LAT(TB_LAT)) dut (
      .CLK(clk), .nRST(nRST), .dren(dren), .dwen(dwen),
      .dmemaddr(dmemaddr), .dstore(dstore),
      .dhit(dhit), .dmemload(dmemload), .busy(busy), .err(err)
   );

   dmem_responder #(.DEPTH(256), .LAT(0)) dut0 (
      .CLK(clk), .nRST(nRST), .dren(dren0), .dwen(dwen0),
      .dmemaddr(addr0), .dstore(data0),
      .dhit(dhit0), .dmemload(load0), .busy(busy0), .err(err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One request on the LAT=2 instance: push expectation, drive, wait for dhit.
   task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input string name);
      exp_t e;
      int   k;
      logic mis;
      mis = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
      mis = (addr[1:0] != 2'b00);
`endif
      e.err = mis;
      if (wr) begin
         e.data = 32'd0;
         if (!mis) model[addr[9:2]] = data;
      end else begin
         e.data = mis ? 32'hBAD0BAD0 : model[addr[9:2]];
      end
      sb.push_back(e);
      dren = rd; dwen = wr; dmemaddr = addr; dstore = data;
      k = 0;
      @(negedge clk);
      // Scramble address/data after capture; the DUT must ignore them.
      dmemaddr = ~addr; dstore = ~data;
      while (dhit !== 1'b1 && k < 20) begin
         n_checks++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_wait: got %b expected 1 (cycle %0d)", name, busy, k);
         end
         k++;
         @(negedge clk);
      end
      n_checks++;
      if (dhit !== 1'b1) begin
         n_fail++;
         $display("FAIL %s timeout: dhit got %b expected 1 within 20 cycles", name, dhit);
      end else if (k != TB_LAT) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d", name, k, TB_LAT);
      end
      e = sb.pop_front();
      n_checks++;
      if (dmemload !== e.data) begin
         n_fail++;
         $display("FAIL %s dmemload: got %h expected %h", name, dmemload, e.data);
      end
      n_checks++;
      if (err !== e.err) begin
         n_fail++;
         $display("FAIL %s err: got %b expected %b", name, err, e.err);
      end
      dren = 1'b0; dwen = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dhit !== 1'b0 || busy !== 1'b0 || dmemload !== 32'd0) begin
         n_fail++;
         $display("FAIL %s after_resp: dhit/busy/load got %b/%b/%h expected 0/0/0",
                  name, dhit, busy, dmemload);
      end
   endtask

   task automatic test_reset;
      n_checks++;
      if (dhit !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || dmemload !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: dhit/busy/err/load got %b/%b/%b/%h expected 0/0/0/0",
                  dhit, busy, err, dmemload);
      end
      @(negedge clk);
      dwen = 1'b1; dmemaddr = 32'h14; dstore = 32'h7777_7777;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_midwait_busy: got %b expected 1", busy);
      end
      #2 nRST = 1'b0;
      #1;
      n_checks++;
      if (dhit !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || dmemload !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_async: dhit/busy/err/load got %b/%b/%b/%h expected 0/0/0/0",
                  dhit, busy, err, dmemload);
      end
      @(negedge clk);
      dwen = 1'b0;
      nRST = 1'b1;
      @(negedge clk);
      xact(1'b1, 1'b0, 32'h14, 32'd0, "read_after_reset");
   endtask

   task automatic test_write_read;
      xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "write_10");
      xact(1'b1, 1'b0, 32'h10, 32'd0, "read_10");
   endtask

   task automatic test_abort;
      xact(1'b0, 1'b1, 32'h20, 32'h5555_AAAA, "prewrite_20");
      dwen = 1'b1; dmemaddr = 32'h20; dstore = 32'h1234;
      @(negedge clk);
      dwen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (dhit !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: cycle %0d dhit/busy got %b/%b expected 0/0", i, dhit, busy);
         end
      end
      xact(1'b1, 1'b0, 32'h20, 32'd0, "read_after_abort");
   endtask

   task automatic test_priority_wrap;
      xact(1'b1, 1'b1, 32'h400, 32'hA5A5A5A5, "both_req_write");
      xact(1'b1, 1'b0, 32'h0, 32'd0, "wrap_read_0");
   endtask

   task automatic test_misalign;
      xact(1'b0, 1'b1, 32'h13, 32'h0BAD_F00D, "misaligned_write");
      xact(1'b1, 1'b0, 32'h13, 32'd0, "misaligned_read");
      xact(1'b1, 1'b0, 32'h10, 32'd0, "aligned_read_10");
   endtask

   task automatic test_back_to_back;
      int   hits;
      logic prev;
      exp_t e;
      @(negedge clk);
      dwen0 = 1'b1; addr0 = 32'h8; data0 = 32'hCAFEF00D;
      @(negedge clk);
      n_checks++;
      if (dhit0 !== 1'b1 || load0 !== 32'd0) begin
         n_fail++;
         $display("FAIL lat0_write: dhit/load got %b/%h expected 1/00000000", dhit0, load0);
      end
      dwen0 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         e.data = 32'hCAFEF00D; e.err = 1'b0;
         sb.push_back(e);
      end
      dren0 = 1'b1;
      hits = 0; prev = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (dhit0 !== ((i % 2) == 0)) begin
            n_fail++;
            $display("FAIL lat0_pattern: cycle %0d dhit got %b expected %b", i, dhit0, (i % 2) == 0);
         end
         n_checks++;
         if (prev && dhit0) begin
            n_fail++;
            $display("FAIL lat0_consecutive: cycle %0d dhit got 1 expected 0", i);
         end
         prev = dhit0;
         if (dhit0 === 1'b1 && sb.size() > 0) begin
            hits++;
            e = sb.pop_front();
            n_checks++;
            if (load0 !== e.data || err0 !== e.err) begin
               n_fail++;
               $display("FAIL lat0_read: load/err got %h/%b expected %h/%b", load0, err0, e.data, e.err);
            end
         end
      end
      dren0 = 1'b0;
      n_checks++;
      if (hits != 5) begin
         n_fail++;
         $display("FAIL lat0_hit_count: got %0d expected 5", hits);
      end
      sb.delete();
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      for (int i = 0; i < 256; i++) model[i] = 32'd0;
      nRST = 1'b0;
      dren = 1'b0; dwen = 1'b0; dmemaddr = 32'd0; dstore = 32'd0;
      dren0 = 1'b0; dwen0 = 1'b0; addr0 = 32'd0; data0 = 32'd0;
      #1;
      @(negedge clk);
      @(negedge clk);
      nRST = 1'b1;
      test_reset();
      test_write_read();
      test_abort();
      test_priority_wrap();
      test_misalign();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
